qpp_read_addr_gen: RTL
======================

Name: qpp_read_addr_gen

Overview:
Read-side address generator for the turbo interleaver. The write side fills the block buffer in natural order, 0..K-1. This block produces the permuted read order pi(i) = (f1*i + f2*i^2) mod K for i = 0..K-1. It uses an add/compare/subtract recursion with no multipliers and sits between the interleaver control FSM and the buffer read port.

Parameters:
ADDR_W, 13, address/index width; holds K-1 for K=6144
K_SMALL, 1056, small block length; f1=17, f2=66
K_LARGE, 6144, large block length; f1=263, f2=480

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  one-cycle request to begin a block; honoured only in IDLE
block_size  input  1  0 = small (K=1056), 1 = large (K=6144); sampled only when start is accepted
read_enable  input  1  advance request; one address is produced per cycle it is high in RUN
addr  output  ADDR_W  registered interleaved read address pi(i)
index  output  ADDR_W  registered natural index i matching addr
addr_valid  output  1  registered; high for the cycle after an accepted advance
addr_last  output  1  registered; high with addr_valid when index = K-1
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse in DONE state

Behaviour:
- Reset (reset=0, async) values:
  - State IDLE.
  - addr, index, addr_valid, addr_last, busy, done = 0.
  - Internal pi, g and i registers = 0.
- Reset mid-block aborts immediately. The next block needs a fresh start.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch K, f1+f2 and 2*f2 from block_size: small -> 1056, 83, 132; large -> 6144, 743, 960.
  - Load pi=0, g=f1+f2, i=0; go to RUN.
  - start in RUN or DONE is ignored.
  - block_size changes after acceptance are ignored.
- RUN, read_enable=1 (advance accepted on that edge):
  - addr<=pi, index<=i, addr_valid<=1, addr_last<=(i==K-1).
  - pi<=(pi+g) mod K and g<=(g+2*f2) mod K. Both operands are < K, so each mod is one conditional subtract of K.
  - i<=i+1.
- RUN, read_enable=0: state holds, addr_valid<=0, addr_last<=0, addr/index hold their last values.
- RUN, advance with i==K-1: next state DONE. No further addresses are issued even if read_enable stays high.
- DONE: one cycle. done=1, addr_valid=0, addr_last=0; then go to IDLE. busy drops when IDLE is entered.
- Latency: the address for an advance sampled at edge n is visible after edge n. There is exactly one addr_valid per accepted advance and exactly K valid addresses per block.
- Arithmetic is unsigned ADDR_W+1 bits internally. Outputs are always < K; an output >= K is a design error the bench must flag.
- Back-to-back blocks: start in the cycle DONE->IDLE is not accepted. start on the first IDLE cycle is accepted, giving a minimum 2-cycle gap between blocks.

Test Plan:
1. Reset mid-RUN after 10 addresses: all outputs 0 immediately; no addr_valid until the next start; a new start restarts at addr=0, index=0.
2. Small block, read_enable held high:
   - first addresses are 0, 83, 298, 645;
   - index 1055 gives addr=49 with addr_last=1;
   - done pulses one cycle later;
   - exactly 1056 addr_valid cycles.
3. Large block, read_enable held high:
   - first addresses are 0, 743, 2446;
   - index 6143 gives addr=217 with addr_last=1;
   - the collected addr set is a permutation of 0..6143 with no duplicates.
4. Small block with read_enable toggled in a pseudo-random 1/3 pattern: the address sequence is identical to scenario 2; addr/index hold while read_enable=0; addr_valid count is 1056.
5. start pulsed during RUN, and block_size flipped mid-block: no restart, K unchanged, sequence still matches the latched block size; busy stays high until IDLE.
6. Back-to-back:
   - start is asserted in the done cycle and then again on the next cycle;
   - the first start is ignored and the second is accepted;
   - the second block begins at 0 with the newly sampled block_size.

Source files
------------

// File: rtl/qpp_read_addr_gen.sv
// Turbo interleaver read-address generator: emits pi(i) = (f1*i + f2*i^2) mod K
// for i = 0..K-1 using an add/compare/subtract recursion instead of multipliers.
//
// state | meaning
// IDLE  | waiting for start; block parameters latched on acceptance
// RUN   | one address per cycle with read_enable high; exits once i reaches K
// DONE  | single-cycle done pulse, busy still high, start ignored
module qpp_read_addr_gen #(
    parameter int ADDR_W  = 13,
    parameter int K_SMALL = 1056,
    parameter int K_LARGE = 6144
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              block_size,
    input  logic              read_enable,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] index,
    output logic              addr_valid,
    output logic              addr_last,
    output logic              busy,
    output logic              done
);

    localparam int AW1 = ADDR_W + 1;

    localparam int F1_SMALL = 17;
    localparam int F2_SMALL = 66;
    localparam int F1_LARGE = 263;
    localparam int F2_LARGE = 480;

    localparam logic [AW1-1:0] K_S    = AW1'(K_SMALL);
    localparam logic [AW1-1:0] K_L    = AW1'(K_LARGE);
    localparam logic [AW1-1:0] G0_S   = AW1'(F1_SMALL + F2_SMALL);
    localparam logic [AW1-1:0] G0_L   = AW1'(F1_LARGE + F2_LARGE);
    localparam logic [AW1-1:0] DG_S   = AW1'(2 * F2_SMALL);
    localparam logic [AW1-1:0] DG_L   = AW1'(2 * F2_LARGE);
    localparam logic [AW1-1:0] ONE    = AW1'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [AW1-1:0] k_reg;
    logic [AW1-1:0] dg_reg;
    logic [AW1-1:0] pi_r;
    logic [AW1-1:0] g_r;
    logic [AW1-1:0] i_r;

    logic [AW1-1:0] pi_sum;
    logic [AW1-1:0] g_sum;
    logic [AW1-1:0] pi_next;
    logic [AW1-1:0] g_next;

    // Both addends are already reduced below K, so one conditional subtract suffices.
    always_comb begin
        pi_sum  = pi_r + g_r;
        g_sum   = g_r + dg_reg;
        pi_next = (pi_sum >= k_reg) ? (pi_sum - k_reg) : pi_sum;
        g_next  = (g_sum >= k_reg) ? (g_sum - k_reg) : g_sum;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            k_reg      <= '0;
            dg_reg     <= '0;
            pi_r       <= '0;
            g_r        <= '0;
            i_r        <= '0;
            addr       <= '0;
            index      <= '0;
            addr_valid <= 1'b0;
            addr_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    addr_valid <= 1'b0;
                    addr_last  <= 1'b0;
                    done       <= 1'b0;
                    if (start) begin
                        k_reg  <= block_size ? K_L  : K_S;
                        dg_reg <= block_size ? DG_L : DG_S;
                        g_r    <= block_size ? G0_L : G0_S;
                        pi_r   <= '0;
                        i_r    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // i == K only after the final address went out; drain to DONE.
                    if (i_r == k_reg) begin
                        addr_valid <= 1'b0;
                        addr_last  <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else if (read_enable) begin
                        addr       <= pi_r[ADDR_W-1:0];
                        index      <= i_r[ADDR_W-1:0];
                        addr_valid <= 1'b1;
                        addr_last  <= (i_r == (k_reg - ONE));
                        pi_r       <= pi_next;
                        g_r        <= g_next;
                        i_r        <= i_r + ONE;
                    end else begin
                        addr_valid <= 1'b0;
                        addr_last  <= 1'b0;
                    end
                end
                DONE: begin
                    addr_valid <= 1'b0;
                    addr_last  <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    addr_valid <= 1'b0;
                    addr_last  <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
